io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the single port-mapped I/O bus (port_id, out_port, in_port, write_strobe, read_strobe) between two requesters: requester 0 is the processor-side shim and requester 1 is the UART TX loader / status poller.
- The bus output feeds the address decoder, which turns port_id plus the strobes into one-hot read/write selects.
- Each requester issues one read or write at a time and receives a done pulse, plus read data for reads.
- Arbitration is round-robin and transactions are non-preemptive.

Parameters:
- ADDR_W, 16, port_id width.
- DATA_W, 8, data width.
- RD_LAT, 1, cycles from the read_strobe cycle to in_port being valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 transaction request; held until done0.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 port address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 owns the bus.
- done0  out  1  one-cycle completion pulse for requester 0.
- rdata0  out  DATA_W  requester 0 read data; valid while done0 is high, held afterwards.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: identical set for requester 1.
- port_id  out  ADDR_W  bus address to the decoder.
- out_port  out  DATA_W  bus write data.
- write_strobe  out  1  one-cycle write strobe.
- read_strobe  out  1  one-cycle read strobe.
- in_port  in  DATA_W  read data returned from the selected peripheral.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state (asynchronous, reset_n = 0):
  - state = IDLE, rr_ptr = 0.
  - All outputs are 0: port_id, out_port, strobes, gnt*, done*, rdata*, busy.
  - An in-flight transaction is abandoned and no done is issued.
- FSM states: IDLE, XFER, RWAIT, DONE. All outputs are registered.
- IDLE:
  - If any req is high, select a winner; the next state is XFER.
  - With both requesting, the winner is rr_ptr; with one requesting, that one wins.
  - Latch the winner's we, addr and wdata into bus registers.
  - Set rr_ptr to the other requester.
- XFER (exactly 1 cycle):
  - gnt[winner] = 1 and port_id = latched addr.
  - Write: write_strobe = 1, out_port = wdata; next state is DONE.
  - Read: read_strobe = 1; next state is RWAIT, with a counter loaded to RD_LAT.
- RWAIT:
  - port_id is held, strobes are 0.
  - The counter decrements each cycle.
  - When the counter reaches 1, in_port is captured into rdata[winner] at that edge; the next state is DONE.
- DONE (1 cycle):
  - done[winner] = 1 and gnt remains high.
  - port_id, out_port and strobes return to 0.
  - Next state is IDLE.
- Latency, with req seen in IDLE at cycle t:
  - Strobe occurs at t+1.
  - Write done at t+2.
  - Read done at t+2+RD_LAT.
  - A back-to-back write costs 3 cycles per transaction.
- Requester rule: req must be low in the cycle after done, unless a new transaction is intended. The arbiter re-arbitrates only in IDLE, which prevents duplicate issue.
- Bus-idle invariant: outside XFER/RWAIT, port_id = 0 and out_port = 0, so the decoder outputs all zeros.
- Safety invariants:
  - write_strobe and read_strobe are never high together.
  - gnt0 and gnt1 are never high together.
- Non-preemptive:
  - A req dropping mid-transaction is ignored; the transaction completes and done still pulses.
  - A changing addr/wdata mid-transaction is ignored (values are latched).
- rdata of the non-winning requester is unchanged. A write never modifies rdata.

Decomposition:
- Shared package (io_bus_pkg):
  - ADDR_W / DATA_W constants.
  - FSM state enum (IDLE, XFER, RWAIT, DONE).
  - Requester index constants.
- Sub-module rr_arb2: a two-way round-robin picker holding rr_ptr.
  - Inputs: req[1:0], advance.
  - Output: one-hot pick[1:0].
  - The FSM, bus registers and read-capture logic stay in io_bus_arbiter.

Test Plan:
- Reset: hold reset_n low, then toggle reqs.
  - Required: all outputs 0 and busy = 0.
  - Release reset with req0 high, we0 = 1, addr0 = 16'h0004, wdata0 = 8'h41.
  - Required: write_strobe high exactly one cycle at t+1 with port_id = 0004 and out_port = 41; done0 at t+2; gnt1 never high.
- Read, RD_LAT = 2: req1 read of addr1 = 16'h0001, with the model driving in_port = 8'hA5 two cycles after read_strobe.
  - Required: done1 at t+4 and rdata1 = A5; rdata0 unchanged.
- Contention: req0 and req1 rise in the same cycle after reset, each doing a write.
  - Required: requester 0 is granted first, then requester 1.
  - Next, both re-request simultaneously. Required: requester 0 again wins, since rr_ptr returned to 0 after granting 1.
  - No overlapping gnt or strobe at any point.
- Mid-transaction changes: drop req0 and change addr0 to 16'hFFFF during XFER.
  - Required: port_id stays at the latched address; done0 still pulses; no second transaction.
- Reset mid-read: assert reset_n = 0 during RWAIT.
  - Required: immediate return to all-zero outputs, no done1, rdata1 = 0.
  - After release with no reqs, busy = 0.

Source files
------------

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared constants, state type and helpers for the I/O bus arbiter
package io_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] req_onehot(input logic idx);
        return {idx, ~idx};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker holding the priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] pick
);
    import io_bus_pkg::*;

    logic rr_ptr;

    // Pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = req_onehot(rr_ptr);
        end
    end

    // After a grant, priority moves to the requester that did not win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= REQ0;
        end else if (advance && (|pick)) begin
            rr_ptr <= pick[REQ0];
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin, non-preemptive sharing of the port-mapped I/O bus
module io_bus_arbiter #(
    parameter int ADDR_W = io_bus_pkg::ADDR_W,
    parameter int DATA_W = io_bus_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe,
    output logic              read_strobe,
    input  logic [DATA_W-1:0] in_port,
    output logic              busy
);
    import io_bus_pkg::*;

    state_t            state, state_nx;
    logic              win, win_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [1:0]        pick;
    logic [1:0]        gnt_nx, done_nx;
    logic [ADDR_W-1:0] port_id_nx, sel_addr;
    logic [DATA_W-1:0] out_port_nx, sel_wdata;
    logic [DATA_W-1:0] rdata0_nx, rdata1_nx;
    logic              ws_nx, rs_nx, busy_nx, sel_we;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .advance (state == IDLE),
        .pick    (pick)
    );

    // Next state and next registered outputs. The bus registers themselves act as
    // the transaction latch: port_id holds the address through RWAIT, and
    // write_strobe being high in XFER marks the transaction as a write.
    always_comb begin
        state_nx    = state;
        win_nx      = win;
        cnt_nx      = cnt;
        gnt_nx      = 2'b00;
        done_nx     = 2'b00;
        port_id_nx  = '0;
        out_port_nx = '0;
        ws_nx       = 1'b0;
        rs_nx       = 1'b0;
        rdata0_nx   = rdata0;
        rdata1_nx   = rdata1;
        sel_we      = pick[REQ1] ? we1    : we0;
        sel_addr    = pick[REQ1] ? addr1  : addr0;
        sel_wdata   = pick[REQ1] ? wdata1 : wdata0;
        unique case (state)
            IDLE: begin
                if (|pick) begin
                    state_nx   = XFER;
                    win_nx     = pick[REQ1];
                    gnt_nx     = pick;
                    port_id_nx = sel_addr;
                    if (sel_we) begin
                        ws_nx       = 1'b1;
                        out_port_nx = sel_wdata;
                    end else begin
                        rs_nx = 1'b1;
                    end
                end
            end
            XFER: begin
                gnt_nx = req_onehot(win);
                if (write_strobe) begin
                    state_nx = DONE;
                    done_nx  = req_onehot(win);
                end else begin
                    state_nx   = RWAIT;
                    cnt_nx     = 3'(RD_LAT);
                    port_id_nx = port_id;
                end
            end
            RWAIT: begin
                gnt_nx = req_onehot(win);
                if (cnt == 3'd1) begin
                    state_nx = DONE;
                    done_nx  = req_onehot(win);
                    if (win == REQ1) begin
                        rdata1_nx = in_port;
                    end else begin
                        rdata0_nx = in_port;
                    end
                end else begin
                    cnt_nx     = cnt - 3'd1;
                    port_id_nx = port_id;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // All outputs are registered; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            win          <= REQ0;
            cnt          <= 3'd0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            port_id      <= '0;
            out_port     <= '0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            win          <= win_nx;
            cnt          <= cnt_nx;
            gnt0         <= gnt_nx[REQ0];
            gnt1         <= gnt_nx[REQ1];
            done0        <= done_nx[REQ0];
            done1        <= done_nx[REQ1];
            rdata0       <= rdata0_nx;
            rdata1       <= rdata1_nx;
            port_id      <= port_id_nx;
            out_port     <= out_port_nx;
            write_strobe <= ws_nx;
            read_strobe  <= rs_nx;
            busy         <= busy_nx;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter with a transaction-level model
module tb_io_bus_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_v [2];
    logic        we_v [2];
    logic [15:0] addr_v [2];
    logic [7:0]  wdata_v [2];
    logic [7:0]  in_port = 8'h00;
    logic        gnt0, gnt1, done0, done1, write_strobe, read_strobe, busy;
    logic [7:0]  rdata0, rdata1, out_port;
    logic [15:0] port_id;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Transaction-level model: the one transaction currently owning the bus,
    // with the cycle of its strobe and of its done pulse.
    bit          cur_v = 1'b0;
    bit          cur_we = 1'b0;
    bit          cur_w = 1'b0;
    int          cur_s = 0;
    int          cur_d = 0;
    logic [15:0] cur_addr = 16'h0;
    logic [7:0]  cur_wdata = 8'h0;
    logic [7:0]  cur_rv = 8'h0;
    bit          rr = 1'b0;
    logic [7:0]  rdata_exp [2] = '{8'h00, 8'h00};
    bit          use_fix = 1'b0;
    logic [7:0]  fix_val = 8'h00;

    io_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req_v[0]),
        .we0          (we_v[0]),
        .addr0        (addr_v[0]),
        .wdata0       (wdata_v[0]),
        .gnt0         (gnt0),
        .done0        (done0),
        .rdata0       (rdata0),
        .req1         (req_v[1]),
        .we1          (we_v[1]),
        .addr1        (addr_v[1]),
        .wdata1       (wdata_v[1]),
        .gnt1         (gnt1),
        .done1        (done1),
        .rdata1       (rdata1),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Acceptance: the bus is free in the cycle after the previous done; a tie
    // goes to rr, which then points at the requester that lost.
    always @(posedge clk) begin : model
        int k;
        bit w;
        k = cyc;
        if (reset_n && (!cur_v || k > cur_d) && (req_v[0] || req_v[1])) begin
            w         = (req_v[0] && req_v[1]) ? rr : req_v[1];
            rr        = !w;
            cur_v     = 1'b1;
            cur_w     = w;
            cur_we    = we_v[w];
            cur_addr  = addr_v[w];
            cur_wdata = wdata_v[w];
            cur_s     = k + 1;
            cur_d     = cur_we ? k + 2 : k + 2 + RD_LAT;
            cur_rv    = use_fix ? fix_val : 8'($urandom);
        end
        cyc = cyc + 1;
    end

    always @(negedge reset_n) begin
        cur_v = 1'b0;
        rr = 1'b0;
        rdata_exp[0] = 8'h00;
        rdata_exp[1] = 8'h00;
    end

    // Per-cycle comparison of every output against the model, plus the peripheral.
    always @(negedge clk) begin : chk
        int k;
        bit intx;
        logic [1:0] g_exp, d_exp;
        bit ws_e, rs_e;
        logic [15:0] pid_e;
        k = cyc;
        intx = cur_v && k >= cur_s && k <= cur_d;
        if (intx && !cur_we && k == cur_d) rdata_exp[cur_w] = cur_rv;
        g_exp = intx ? (cur_w ? 2'b10 : 2'b01) : 2'b00;
        d_exp = (intx && k == cur_d) ? g_exp : 2'b00;
        ws_e  = intx && cur_we && k == cur_s;
        rs_e  = intx && !cur_we && k == cur_s;
        pid_e = (intx && (k == cur_s || (!cur_we && k < cur_d))) ? cur_addr : 16'h0;
        check_eq("gnt", {gnt1, gnt0}, g_exp);
        check_eq("done", {done1, done0}, d_exp);
        check_eq("write_strobe", write_strobe, ws_e);
        check_eq("read_strobe", read_strobe, rs_e);
        check_eq("port_id", port_id, pid_e);
        check_eq("out_port", out_port, ws_e ? cur_wdata : 8'h00);
        check_eq("busy", busy, intx);
        check_eq("rdata0", rdata0, rdata_exp[0]);
        check_eq("rdata1", rdata1, rdata_exp[1]);
        check_eq("strobe_excl", write_strobe & read_strobe, 1'b0);
        check_eq("gnt_excl", gnt0 & gnt1, 1'b0);
        in_port = (cur_v && !cur_we && k == cur_s + RD_LAT) ? cur_rv : 8'($urandom);
    end

    // Raise a request at the current negedge and hold it until done; returns at
    // the negedge of the done cycle with req still high.
    task automatic txn(input int r, input bit we, input logic [15:0] a, input logic [7:0] d,
                       input bit mid, output int sc, output int dc);
        int n;
        bit mid_done;
        req_v[r] = 1'b1;
        we_v[r] = we;
        addr_v[r] = a;
        wdata_v[r] = d;
        sc = cyc;
        dc = -1;
        n = 0;
        mid_done = 1'b0;
        while (dc < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if ((r == 0) ? done0 : done1) begin
                dc = cyc;
            end else if (mid && !mid_done && ((r == 0) ? gnt0 : gnt1)) begin
                req_v[r] = 1'b0;
                addr_v[r] = 16'hFFFF;
                wdata_v[r] = 8'($urandom);
                mid_done = 1'b1;
            end
        end
        if (dc < 0) check_eq("done_timeout", (r == 0) ? done0 : done1, 1'b1);
    endtask

    task automatic requester(input int r);
        int gap, sc, dc;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            txn(r, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), sc, dc);
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                req_v[r] = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        req_v[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, dc, s0, d0, s1, d1, n;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;
            we_v[i] = 1'b0;
            addr_v[i] = 16'h0;
            wdata_v[i] = 8'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_v[0] = 1'($urandom);
            req_v[1] = 1'($urandom);
            we_v[0] = 1'($urandom);
            addr_v[1] = 16'($urandom);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_port_id", port_id, 16'h0);
        end
        @(negedge clk);
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        reset_n = 1'b1;
        txn(0, 1'b1, 16'h0004, 8'h41, 1'b0, sc, dc);
        req_v[0] = 1'b0;
        check_eq("wr_latency", dc - sc, 2);

        @(negedge clk);
        use_fix = 1'b1;
        fix_val = 8'hA5;
        txn(1, 1'b0, 16'h0001, 8'h00, 1'b0, sc, dc);
        use_fix = 1'b0;
        req_v[1] = 1'b0;
        check_eq("rd_latency", dc - sc, 2 + RD_LAT);
        check_eq("rd_data1", rdata1, 8'hA5);
        check_eq("rd_keep0", rdata0, 8'h00);

        for (int rnd = 0; rnd < 2; rnd++) begin
            @(negedge clk);
            fork
                begin
                    txn(0, 1'b1, 16'h0010 + 16'(rnd), 8'h11, 1'b0, s0, d0);
                    req_v[0] = 1'b0;
                end
                begin
                    txn(1, 1'b1, 16'h0020 + 16'(rnd), 8'h22, 1'b0, s1, d1);
                    req_v[1] = 1'b0;
                end
            join
            check_eq("rr_first0", d0 < d1, 1'b1);
            check_eq("rr_gap", d1 - d0, 3);
        end

        @(negedge clk);
        txn(0, 1'b1, 16'h0030, 8'h5A, 1'b1, sc, dc);
        req_v[0] = 1'b0;
        check_eq("mid_latency", dc - sc, 2);
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_no_dup", gnt0, 1'b0);
        end

        @(negedge clk);
        req_v[1] = 1'b1;
        we_v[1] = 1'b0;
        addr_v[1] = 16'h0002;
        n = 0;
        while (!read_strobe && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("mr_strobe", read_strobe, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        req_v[1] = 1'b0;
        #1;
        check_eq("mr_done1", done1, 1'b0);
        check_eq("mr_rdata1", rdata1, 8'h00);
        check_eq("mr_busy", busy, 1'b0);
        check_eq("mr_gnt1", gnt1, 1'b0);
        check_eq("mr_port_id", port_id, 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", busy, 1'b0);

        fork
            requester(0);
            requester(1);
        join
        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
